// File: rtl/som_pkg.sv
// Shared types and default constants for the SOM sequencing controller.
package som_pkg;

  localparam int unsigned DefAddrW   = 18;
  localparam int unsigned DefNPix    = 4096;
  localparam int unsigned DefNNeur   = 64;
  localparam int unsigned DefEpochs  = 1;
  localparam int unsigned DefDistLat = 3;

  typedef enum logic [3:0] {
    StIdle,
    StTRd,
    StTDist,
    StTUpd,
    StWWr,
    StCRd,
    StCDist,
    StCWr,
    StDone
  } som_state_e;

  // Counter width that holds values 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/som_term_cnt.sv
// Saturating up-counter with synchronous clear, enable and terminal-count flag.
module som_term_cnt #(
  parameter int unsigned Width    = 4,
  parameter int unsigned Terminal = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [Width-1:0] cnt_o,
  output logic             term_o
);

  localparam logic [Width-1:0] TermVal = Width'(Terminal);

  logic [Width-1:0] cnt_q, cnt_d;

  assign term_o = (cnt_q == TermVal);
  assign cnt_o  = cnt_q;

  // Clear wins over enable; the count holds at its terminal value.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !term_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/som_seq_ctrl.sv
// SOM engine sequencer: multi-epoch training, weight write-back, then a
// classification pass writing one winner per pixel.
module som_seq_ctrl
  import som_pkg::*;
#(
  parameter int unsigned ADDR_W   = DefAddrW,
  parameter int unsigned N_PIX    = DefNPix,
  parameter int unsigned N_NEUR   = DefNNeur,
  parameter int unsigned EPOCHS   = DefEpochs,
  parameter int unsigned DIST_LAT = DefDistLat
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         classify_only,
  output logic                         d_update,
  output logic                         w_update,
  output logic                         ram_if_oe,
  output logic [ADDR_W-1:0]            ram_if_a,
  output logic                         ram_w_we,
  output logic [ADDR_W-1:0]            ram_w_a,
  output logic                         ram_result_we,
  output logic [ADDR_W-1:0]            ram_result_a,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(EPOCHS+1)-1:0]  epoch
);

  localparam int unsigned PixW  = cnt_w(N_PIX);
  localparam int unsigned NeurW = cnt_w(N_NEUR);
  localparam int unsigned LatW  = cnt_w(DIST_LAT + 1);
  localparam int unsigned EpW   = $clog2(EPOCHS + 1);

  som_state_e state_q, state_d;

  logic [PixW-1:0]  pix;
  logic [NeurW-1:0] nidx;
  logic [LatW-1:0]  lat;
  logic             pix_term, nidx_term, lat_term, ep_term;
  logic             pix_clr, pix_en, nidx_clr, nidx_en;
  logic             lat_clr, lat_en, ep_clr, ep_en;

  som_term_cnt #(.Width(PixW), .Terminal(N_PIX - 1)) u_pix_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (pix_clr),
    .en_i   (pix_en),
    .cnt_o  (pix),
    .term_o (pix_term)
  );

  som_term_cnt #(.Width(NeurW), .Terminal(N_NEUR - 1)) u_nidx_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (nidx_clr),
    .en_i   (nidx_en),
    .cnt_o  (nidx),
    .term_o (nidx_term)
  );

  som_term_cnt #(.Width(LatW), .Terminal(DIST_LAT - 1)) u_lat_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (lat_clr),
    .en_i   (lat_en),
    .cnt_o  (lat),
    .term_o (lat_term)
  );

  som_term_cnt #(.Width(EpW), .Terminal(EPOCHS - 1)) u_ep_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (ep_clr),
    .en_i   (ep_en),
    .cnt_o  (epoch),
    .term_o (ep_term)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pix_clr  = 1'b0;
    pix_en   = 1'b0;
    nidx_clr = 1'b0;
    nidx_en  = 1'b0;
    lat_clr  = 1'b0;
    lat_en   = 1'b0;
    ep_clr   = 1'b0;
    ep_en    = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          pix_clr = 1'b1;
          if (classify_only) begin
            state_d = StCRd;
          end else begin
            ep_clr  = 1'b1;
            state_d = StTRd;
          end
        end
      end
      StTRd: begin
        lat_clr = 1'b1;
        state_d = StTDist;
      end
      StTDist: begin
        if (lat_term) state_d = StTUpd;
        else          lat_en  = 1'b1;
      end
      StTUpd: begin
        if (!pix_term) begin
          pix_en  = 1'b1;
          state_d = StTRd;
        end else if (!ep_term) begin
          ep_en   = 1'b1;
          pix_clr = 1'b1;
          state_d = StTRd;
        end else begin
          nidx_clr = 1'b1;
          state_d  = StWWr;
        end
      end
      StWWr: begin
        if (nidx_term) begin
          pix_clr = 1'b1;
          state_d = StCRd;
        end else begin
          nidx_en = 1'b1;
        end
      end
      StCRd: begin
        lat_clr = 1'b1;
        state_d = StCDist;
      end
      StCDist: begin
        if (lat_term) state_d = StCWr;
        else          lat_en  = 1'b1;
      end
      StCWr: begin
        if (pix_term) begin
          state_d = StDone;
        end else begin
          pix_en  = 1'b1;
          state_d = StCRd;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Moore output decode; addresses track their counters, so they hold in IDLE/DONE.
  always_comb begin
    d_update      = (state_q == StTDist) || (state_q == StCDist);
    w_update      = (state_q == StTUpd);
    ram_if_oe     = (state_q == StTRd) || (state_q == StTDist) ||
                    (state_q == StCRd) || (state_q == StCDist);
    ram_w_we      = (state_q == StWWr);
    ram_result_we = (state_q == StCWr);
    busy          = (state_q != StIdle) && (state_q != StDone);
    done          = (state_q == StDone);
    ram_if_a                 = '0;
    ram_if_a[PixW-1:0]       = pix;
    ram_result_a             = '0;
    ram_result_a[PixW-1:0]   = pix;
    ram_w_a                  = '0;
    ram_w_a[NeurW-1:0]       = nidx;
  end

endmodule

// File: tb/tb_som_seq_ctrl.sv
// Directed bench: small-config sequencer (full, classify-only, busy start,
// mid-run reset, restart from DONE) plus one default-parameter full run.
module tb_som_seq_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Small configuration: N_PIX=4, N_NEUR=3, EPOCHS=2, DIST_LAT=2
  logic       s_start = 1'b0, s_co = 1'b0;
  logic       s_d_update, s_w_update, s_ram_if_oe, s_ram_w_we, s_ram_result_we;
  logic       s_busy, s_done;
  logic [7:0] s_ram_if_a, s_ram_w_a, s_ram_result_a;
  logic [1:0] s_epoch;

  som_seq_ctrl #(
    .ADDR_W(8), .N_PIX(4), .N_NEUR(3), .EPOCHS(2), .DIST_LAT(2)
  ) u_small (
    .clk           (clk),
    .rst           (rst),
    .start         (s_start),
    .classify_only (s_co),
    .d_update      (s_d_update),
    .w_update      (s_w_update),
    .ram_if_oe     (s_ram_if_oe),
    .ram_if_a      (s_ram_if_a),
    .ram_w_we      (s_ram_w_we),
    .ram_w_a       (s_ram_w_a),
    .ram_result_we (s_ram_result_we),
    .ram_result_a  (s_ram_result_a),
    .busy          (s_busy),
    .done          (s_done),
    .epoch         (s_epoch)
  );

  // Default configuration
  logic        b_start = 1'b0, b_co = 1'b0;
  logic        b_d_update, b_w_update, b_ram_if_oe, b_ram_w_we, b_ram_result_we;
  logic        b_busy, b_done;
  logic [17:0] b_ram_if_a, b_ram_w_a, b_ram_result_a;
  logic [0:0]  b_epoch;

  som_seq_ctrl u_big (
    .clk           (clk),
    .rst           (rst),
    .start         (b_start),
    .classify_only (b_co),
    .d_update      (b_d_update),
    .w_update      (b_w_update),
    .ram_if_oe     (b_ram_if_oe),
    .ram_if_a      (b_ram_if_a),
    .ram_w_we      (b_ram_w_we),
    .ram_w_a       (b_ram_w_a),
    .ram_result_we (b_ram_result_we),
    .ram_result_a  (b_ram_result_a),
    .busy          (b_busy),
    .done          (b_done),
    .epoch         (b_epoch)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Mid-cycle monitors; tasks snapshot these and compare deltas.
  int         s_busy_cnt = 0, s_wupd_cnt = 0, s_conf_cnt = 0;
  logic [7:0] s_wa_q[$];
  logic [7:0] s_ra_q[$];
  int         b_busy_cnt = 0, b_res_cnt = 0, b_max_ep = 0;

  always @(negedge clk) begin
    if (s_busy)          s_busy_cnt++;
    if (s_w_update)      s_wupd_cnt++;
    if (s_ram_w_we)      s_wa_q.push_back(s_ram_w_a);
    if (s_ram_result_we) s_ra_q.push_back(s_ram_result_a);
    if (s_d_update && (s_w_update || s_ram_w_we || s_ram_result_we)) s_conf_cnt++;
    if (b_busy)          b_busy_cnt++;
    if (b_ram_result_we) b_res_cnt++;
    if (int'(b_epoch) > b_max_ep) b_max_ep = int'(b_epoch);
  end

  task automatic check_small_zero(input string tag);
    check({tag, "_strobes"}, 32'({s_d_update, s_w_update, s_ram_if_oe, s_ram_w_we,
                                  s_ram_result_we, s_busy, s_done}), 32'd0);
    check({tag, "_addrs"}, 32'({s_ram_if_a, s_ram_w_a, s_ram_result_a}), 32'd0);
    check({tag, "_epoch"}, 32'(s_epoch), 32'd0);
  endtask

  task automatic run_small(input string tag, input logic co, input logic poke,
                           input int unsigned exp_busy, input int unsigned exp_wupd,
                           input int unsigned exp_wwe);
    int b0, w0, c0, wq0, rq0;
    bit seen, poked;
    b0 = s_busy_cnt; w0 = s_wupd_cnt; c0 = s_conf_cnt;
    wq0 = s_wa_q.size(); rq0 = s_ra_q.size();
    s_start = 1'b1; s_co = co;
    @(posedge clk); #1;
    s_start = 1'b0; s_co = 1'b0;
    check({tag, "_accept_busy_done_oe"}, 32'({s_busy, s_done, s_ram_if_oe}), 32'b101);
    check({tag, "_accept_pix0"}, 32'(s_ram_if_a), 32'd0);
    if (!co) check({tag, "_accept_ep0"}, 32'(s_epoch), 32'd0);
    seen = 0; poked = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (s_done) begin
        seen = 1;
        break;
      end
      if (poke && !poked && s_d_update) begin
        s_start = 1'b1; s_co = 1'b1; poked = 1;
      end else begin
        s_start = 1'b0; s_co = 1'b0;
      end
    end
    s_start = 1'b0; s_co = 1'b0;
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_busy_cycles"}, 32'(s_busy_cnt - b0), exp_busy);
    check({tag, "_w_update_cnt"}, 32'(s_wupd_cnt - w0), exp_wupd);
    check({tag, "_w_we_cnt"}, 32'(s_wa_q.size() - wq0), exp_wwe);
    check({tag, "_result_cnt"}, 32'(s_ra_q.size() - rq0), 32'd4);
    check({tag, "_d_update_overlap"}, 32'(s_conf_cnt - c0), 32'd0);
    for (int i = 0; i < s_wa_q.size() - wq0; i++)
      check({tag, "_w_addr_seq"}, 32'(s_wa_q[wq0 + i]), 32'(i));
    for (int i = 0; i < s_ra_q.size() - rq0; i++)
      check({tag, "_result_addr_seq"}, 32'(s_ra_q[rq0 + i]), 32'(i));
  endtask

  initial begin
    bit found;
    #2;
    check_small_zero("reset");
    check("reset_big_strobes", 32'({b_d_update, b_w_update, b_ram_if_oe, b_ram_w_we,
                                   b_ram_result_we, b_busy, b_done}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check_small_zero("idle");

    // Full run: 3*4*4 + 3 = 51 busy cycles, 2*4 weight updates
    run_small("full", 1'b0, 1'b0, 51, 8, 3);
    check("full_final_epoch", 32'(s_epoch), 32'd1);
    check("full_final_result_a", 32'(s_ram_result_a), 32'd3);

    run_small("classify", 1'b1, 1'b0, 16, 0, 0);

    run_small("busy_start", 1'b0, 1'b1, 51, 8, 3);

    // Abort during weight write-back at nidx=1
    s_start = 1'b1; s_co = 1'b0;
    @(posedge clk); #1;
    s_start = 1'b0;
    found = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (s_ram_w_we && s_ram_w_a == 8'd1) begin
        found = 1;
        break;
      end
    end
    check("abort_reached_nidx1", 32'(found), 32'd1);
    #1 rst = 1'b1;
    #1;
    check_small_zero("abort_async");
    @(negedge clk);
    check_small_zero("abort_next");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check_small_zero("abort_idle");

    run_small("rerun", 1'b0, 1'b0, 51, 8, 3);

    check("done_before_restart", 32'(s_done), 32'd1);
    run_small("from_done", 1'b0, 1'b0, 51, 8, 3);

    // Default parameters: 2*4096*5 + 64 busy cycles
    begin
      int bb0, br0;
      bit bseen;
      bb0 = b_busy_cnt; br0 = b_res_cnt;
      @(posedge clk); #1;
      b_start = 1'b1;
      @(posedge clk); #1;
      b_start = 1'b0;
      check("big_accept_oe", 32'({b_busy, b_ram_if_oe}), 32'b11);
      bseen = 0;
      for (int i = 0; i < 50000; i++) begin
        @(negedge clk);
        if (b_done) begin
          bseen = 1;
          break;
        end
      end
      check("big_done_seen", 32'(bseen), 32'd1);
      check("big_busy_cycles", 32'(b_busy_cnt - bb0), 32'd41024);
      check("big_result_cnt", 32'(b_res_cnt - br0), 32'd4096);
      check("big_final_result_a", 32'(b_ram_result_a), 32'd4095);
      check("big_max_epoch", 32'(b_max_ep), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
